// File: rtl/y_zigzag_rle_if.sv
// y_zigzag_rle_if: block capture and symbol handshake bundle for the zigzag/RLE stage
interface y_zigzag_rle_if #(parameter int COEF_W = 11);
  logic in_valid, in_ready, dc_clear;
  logic [7:0][7:0][COEF_W-1:0] coef_in;
  logic sym_valid, sym_ready, sym_is_dc, sym_eob;
  logic [3:0] sym_run, sym_size;
  logic [COEF_W-1:0] sym_amp;
  modport slave (input in_valid, coef_in, dc_clear, sym_ready,
                 output in_ready, sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_eob);
  modport master (output in_valid, coef_in, dc_clear, sym_ready,
                  input in_ready, sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_eob);
endinterface

// File: rtl/y_zigzag_rle.sv
// y_zigzag_rle: captures a quantized 8x8 Y block, emits DC diff then zigzag-ordered AC run/size/amp symbols
module y_zigzag_rle #(parameter int COEF_W = 11) (
  input logic clk,
  input logic rst,
  y_zigzag_rle_if.slave bus
);
  localparam int ZZ [64] = '{
    0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
   12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
   35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
   58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};
  typedef enum logic [1:0] {IDLE, DC, AC, EOB} state_t;
  state_t state_q, state_d;
  logic [5:0] k_q, k_d, last_q, last_d;
  logic [3:0] run_q, run_d, sz_dc, sz_ac;
  logic nz_q, nz_d, cap;
  logic [COEF_W-1:0] pred_q, pred_d, cur;
  logic [COEF_W:0] diff_q, diff_d, cur_x;
  logic [COEF_W-1:0] zz_q [64];
  logic [COEF_W-1:0] zz_d [64];
  function automatic logic [3:0] size_of(input logic [COEF_W:0] v);
    logic [COEF_W:0] a;
    a = v[COEF_W] ? -v : v;
    size_of = '0;
    for (int i = 0; i <= COEF_W; i++) if (a[i]) size_of = 4'(i + 1);
  endfunction
  function automatic logic [COEF_W-1:0] amp_of(input logic [COEF_W:0] v, input logic [3:0] s);
    logic [COEF_W:0] m;
    m = ~({(COEF_W+1){1'b1}} << s);
    amp_of = COEF_W'((v[COEF_W] ? v - (COEF_W+1)'(1) : v) & m);
  endfunction
  assign cap = bus.in_valid && state_q == IDLE;
  for (genvar i = 0; i < 64; i++) begin : g_zz
    assign zz_d[i] = cap ? bus.coef_in[ZZ[i]/8][ZZ[i]%8] : zz_q[i];
  end
  assign cur = zz_q[k_q];
  assign cur_x = {cur[COEF_W-1], cur};
  assign sz_dc = size_of(diff_q);
  assign sz_ac = size_of(cur_x);
  always_comb begin
    last_d = cap ? '0 : last_q;
    nz_d = cap ? 1'b0 : nz_q;
    if (cap) for (int i = 1; i < 64; i++) if (zz_d[i] != '0) begin
      last_d = 6'(i);
      nz_d = 1'b1;
    end
    diff_d = cap ? {zz_d[0][COEF_W-1], zz_d[0]} - (bus.dc_clear ? '0 : {pred_q[COEF_W-1], pred_q}) : diff_q;
    pred_d = cap ? zz_d[0] : (state_q == IDLE && bus.dc_clear) ? '0 : pred_q;
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    run_d = run_q;
    bus.in_ready = state_q == IDLE;
    bus.sym_valid = 1'b0;
    bus.sym_is_dc = 1'b0;
    bus.sym_eob = 1'b0;
    bus.sym_run = '0;
    bus.sym_size = '0;
    bus.sym_amp = '0;
    case (state_q)
      IDLE: state_d = cap ? DC : IDLE;
      DC: begin
        bus.sym_valid = 1'b1;
        bus.sym_is_dc = 1'b1;
        bus.sym_size = sz_dc;
        bus.sym_amp = amp_of(diff_q, sz_dc);
        if (bus.sym_ready) begin
          state_d = nz_q ? AC : EOB;
          k_d = 6'd1;
          run_d = '0;
        end
      end
      AC: begin
        if (cur == '0 && run_q != 4'd15) begin
          run_d = run_q + 4'd1;
          k_d = k_q + 6'd1;
        end else begin
          // a zero reaching here is the 16th of a run, i.e. ZRL with size 0
          bus.sym_valid = 1'b1;
          bus.sym_run = run_q;
          bus.sym_size = sz_ac;
          bus.sym_amp = amp_of(cur_x, sz_ac);
          if (bus.sym_ready) begin
            run_d = '0;
            k_d = k_q + 6'd1;
            if (cur != '0 && k_q == last_q) state_d = last_q != 6'd63 ? EOB : IDLE;
          end
        end
      end
      EOB: begin
        bus.sym_valid = 1'b1;
        bus.sym_eob = 1'b1;
        state_d = bus.sym_ready ? IDLE : EOB;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      run_q <= '0;
      last_q <= '0;
      nz_q <= 1'b0;
      pred_q <= '0;
      diff_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      run_q <= run_d;
      last_q <= last_d;
      nz_q <= nz_d;
      pred_q <= pred_d;
      diff_q <= diff_d;
    end
  end
  always_ff @(posedge clk) zz_q <= zz_d;
endmodule

// File: tb/tb_y_zigzag_rle.sv
// tb_y_zigzag_rle: directed scenarios for the Y zigzag/RLE stage with hand-derived symbol streams
module tb_y_zigzag_rle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  y_zigzag_rle_if #(.COEF_W(11)) bus();
  y_zigzag_rle #(.COEF_W(11)) dut(.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  int stall_err, low_cyc, acc_cyc, rdy_cyc;
  logic tmo;
  logic [20:0] got[$];
  logic [7:0][7:0][10:0] blk;

  function automatic logic [20:0] s(input logic dc, input logic eob, input int run, input int size, input logic [10:0] amp);
    return {dc, eob, 4'(run), 4'(size), amp};
  endfunction
  function automatic logic [20:0] cur_sym();
    return {bus.sym_is_dc, bus.sym_eob, bus.sym_run, bus.sym_size, bus.sym_amp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic clr);
    bus.coef_in = blk;
    bus.in_valid = 1'b1;
    bus.dc_clear = clr;
    tick();
    bus.in_valid = 1'b0;
    bus.dc_clear = 1'b0;
  endtask

  task automatic collect(input int stall, input logic poke);
    int w = 0;
    logic hv = 1'b0;
    logic [21:0] held = '0;
    got.delete();
    stall_err = 0; low_cyc = 0; acc_cyc = -1; rdy_cyc = -1; tmo = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (bus.in_ready) begin
        rdy_cyc = c;
        tmo = 1'b0;
        break;
      end
      low_cyc++;
      if (hv && {bus.sym_valid, cur_sym()} !== held) stall_err++;
      hv = 1'b0;
      bus.sym_ready = 1'b0;
      if (bus.sym_valid) begin
        if (w < stall) begin
          w++;
          held = {1'b1, cur_sym()};
          hv = 1'b1;
        end else begin
          w = 0;
          bus.sym_ready = 1'b1;
          got.push_back(cur_sym());
          acc_cyc = c;
        end
      end
      bus.in_valid = poke;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.sym_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL reset sym_valid got=%b exp=0", bus.sym_valid); end
    checks++; if (cur_sym() !== 21'h0) begin errors++; $display("FAIL reset sym_fields got=%h exp=0", cur_sym()); end
  endtask

  task automatic test_all_zero();
    logic [20:0] exp[$];
    blk = '0;
    start(1'b0);
    collect(0, 1'b0);
    exp = '{s(1,0,0,0,0), s(0,1,0,0,0)};
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL zero timeout got=%b exp=0", tmo); end
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL zero count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL zero sym%0d got=%h exp=%h", i, i < got.size() ? got[i] : 21'h0, exp[i]); end
    end
    checks++; if (low_cyc != 2) begin errors++; $display("FAIL zero ready_low got=%0d exp=2", low_cyc); end
  endtask

  task automatic test_dc_pred();
    logic [20:0] exp[$];
    blk = '0; blk[0][0] = 11'd5;
    start(1'b0);
    collect(0, 1'b0);
    exp = '{s(1,0,0,3,11'b101), s(0,1,0,0,0)};
    blk[0][0] = 11'd3;
    start(1'b0);
    collect(0, 1'b0);
    for (int i = 0; i < got.size(); i++) exp.push_back(21'h0);
    exp[2] = s(1,0,0,2,11'b01); exp[3] = s(0,1,0,0,0);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL dcpred count got=%0d exp=2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (i >= got.size() || got[i] !== exp[i+2]) begin errors++; $display("FAIL dcpred second sym%0d got=%h exp=%h", i, i < got.size() ? got[i] : 21'h0, exp[i+2]); end
    end
  endtask

  task automatic test_dc_first();
    blk = '0; blk[0][0] = 11'd5;
    start(1'b1);
    collect(0, 1'b0);
    checks++; if (got.size() < 1 || got[0] !== s(1,0,0,3,11'b101)) begin errors++; $display("FAIL dc5 got=%h exp=%h", got.size() ? got[0] : 21'h0, s(1,0,0,3,11'b101)); end
  endtask

  task automatic test_ac_runs(input int stall, input logic poke);
    logic [20:0] exp[$];
    blk = '0; blk[0][1] = 11'h7FF; blk[5][0] = 11'd7;
    start(1'b1);
    collect(stall, poke);
    exp = '{s(1,0,0,0,0), s(0,0,0,1,0), s(0,0,15,0,0), s(0,0,2,3,11'b111), s(0,1,0,0,0)};
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ac stall%0d count got=%0d exp=%0d", stall, got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL ac stall%0d sym%0d got=%h exp=%h", stall, i, i < got.size() ? got[i] : 21'h0, exp[i]); end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL ac stall%0d hold got=%0d exp=0", stall, stall_err); end
  endtask

  task automatic test_last63();
    logic [20:0] exp[$];
    blk = '0; blk[7][7] = 11'd1;
    start(1'b0);
    collect(0, 1'b0);
    exp = '{s(1,0,0,0,0), s(0,0,15,0,0), s(0,0,15,0,0), s(0,0,15,0,0), s(0,0,14,1,1)};
    checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL last63 count got=%0d exp=%0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++; if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL last63 sym%0d got=%h exp=%h", i, i < got.size() ? got[i] : 21'h0, exp[i]); end
    end
    checks++; if (rdy_cyc - acc_cyc != 1) begin errors++; $display("FAIL last63 ready_gap got=%0d exp=1", rdy_cyc - acc_cyc); end
  endtask

  task automatic test_rst_mid();
    blk = '0; blk[0][0] = 11'd9; blk[7][6] = 11'd1;
    start(1'b0);
    bus.sym_ready = 1'b1;
    tick();
    bus.sym_ready = 1'b0;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid busy got=%b exp=0", bus.in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.in_ready, bus.sym_valid} !== 2'b10) begin errors++; $display("FAIL rstmid idle got=%b exp=10", {bus.in_ready, bus.sym_valid}); end
    blk = '0; blk[0][0] = 11'd4;
    start(1'b0);
    collect(0, 1'b0);
    checks++; if (got.size() != 2 || got[0] !== s(1,0,0,3,11'b100) || got[1] !== s(0,1,0,0,0)) begin
      errors++; $display("FAIL rstmid dc4 got=%h exp=%h n=%0d", got.size() ? got[0] : 21'h0, s(1,0,0,3,11'b100), got.size());
    end
  endtask

  task automatic test_dc_clear();
    blk = '0; blk[0][0] = 11'd6;
    start(1'b0);
    collect(0, 1'b0);
    checks++; if (got.size() < 1 || got[0] !== s(1,0,0,2,11'b10)) begin errors++; $display("FAIL clr dc6 got=%h exp=%h", got.size() ? got[0] : 21'h0, s(1,0,0,2,11'b10)); end
    blk[0][0] = 11'h7FD;
    start(1'b1);
    collect(0, 1'b0);
    checks++; if (got.size() < 1 || got[0] !== s(1,0,0,2,11'b00)) begin errors++; $display("FAIL clr dcm3 got=%h exp=%h", got.size() ? got[0] : 21'h0, s(1,0,0,2,11'b00)); end
    bus.dc_clear = 1'b1;
    tick();
    bus.dc_clear = 1'b0;
    test_dc_first();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.dc_clear = 1'b0; bus.sym_ready = 1'b0; bus.coef_in = '0;
    blk = '0;
    test_reset();
    test_all_zero();
    test_dc_pred();
    test_ac_runs(0, 1'b0);
    test_last63();
    test_ac_runs(3, 1'b1);
    test_rst_mid();
    test_dc_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/y_zigzag_rle.md
Name: y_zigzag_rle

Overview:
Luminance entropy-prep stage directly downstream of the Y quantizer. It captures one quantized 8x8 block, walks it in JPEG zigzag order, and emits one symbol per handshake for the Huffman encoder:
- a DC difference symbol first,
- then AC (run, size, amplitude) symbols,
- ZRL and EOB symbols where required.

It keeps the DC predictor across blocks.

Parameters:
COEF_W, 11, signed coefficient width; legal range 8..11; size fields are 4 bits.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  quantized block available on coef_in
in_ready  output  1  block capture possible; high only in IDLE
coef_in  input  8x8 x COEF_W  quantized block, [row][col], two's complement
dc_clear  input  1  zero the DC predictor (frame/restart boundary); sampled in IDLE only
sym_valid  output  1  symbol present
sym_ready  input  1  downstream accepts symbol
sym_run  output  4  zero run preceding an AC coefficient (ZRL = 15)
sym_size  output  4  magnitude category (bit length of |value|); 0 for value 0, ZRL, EOB
sym_amp  output  COEF_W  JPEG amplitude bits, right-aligned, bits above sym_size are zero
sym_is_dc  output  1  symbol is the DC difference
sym_eob  output  1  symbol is EOB

Behaviour:
- Reset values: in_ready=1, sym_valid=0, sym_run=0, sym_size=0, sym_amp=0, sym_is_dc=0, sym_eob=0. DC predictor=0, state=IDLE.
- Reset mid-block discards the block and any pending symbol. The next cycle is IDLE.
- Capture: in_valid&&in_ready at edge N latches all 64 coefficients into a zigzag-ordered buffer zz[0..63]. Order is standard JPEG: 0=(0,0), 1=(0,1), 2=(1,0), 3=(2,0), 4=(1,1), 5=(0,2), 6=(0,3) ... 63=(7,7).
- At the same edge:
  - last_nz = highest AC index with nonzero value; none if all AC are zero.
  - diff = zz[0] - pred, computed in COEF_W+1 bits.
  - pred <= zz[0].
  - If dc_clear is high in that same cycle, pred is 0 for this diff.
- dc_clear without in_valid in IDLE sets pred=0. dc_clear is ignored outside IDLE.
- Amplitude rule: v>=0 gives v; v<0 gives (v-1) truncated to size bits. The size of the DC diff can reach COEF_W.
- States:
  - IDLE: waits for capture.
  - DC: sym_valid=1, is_dc=1, run=0, size/amp of diff. On accept: go to AC with k=1, run=0 if last_nz exists, else go to EOB.
  - AC: examines zz[k] once per cycle.
    - Zero and run<15: run++, k++, sym_valid=0.
    - Zero and run==15: present ZRL (run=15, size=0, amp=0). On accept: run=0, k++.
    - Nonzero: present (run, size, amp). On accept: run=0. If k==last_nz, go to EOB when last_nz<63, else to IDLE. Otherwise k++.
  - EOB: sym_valid=1, sym_eob=1, run=0, size=0. On accept: go to IDLE.
- Latency: capture at edge N puts the DC symbol valid in cycle N+1. in_ready returns high the cycle after the final symbol is accepted.
- Handshake:
  - A symbol transfers on sym_valid&&sym_ready.
  - While sym_valid&&!sym_ready, all sym_* outputs hold stable and the state does not advance.
  - sym_valid never drops without a transfer, except on rst.
  - There is no combinational path from sym_ready to sym_valid.
- ZRL is never emitted after the last nonzero coefficient; trailing zeros are covered only by EOB.
- EOB is omitted when zz[63] is nonzero.
- Throughput: at most one symbol per cycle; zero coefficients cost one cycle each.

Test Plan:
1. After reset, capture an all-zero block -> exactly DC (is_dc=1, size=0, amp=0), then EOB (eob=1); in_ready low for 2 cycles with sym_ready=1.
2. Block DC=5, then a block with DC=3, AC all zero -> first DC size=3 amp=101b; second DC diff=-2, size=2 amp=01b; each followed by EOB.
3. DC=0, zz[1]=-1, zz[20]=7, rest zero -> DC(0,0); (run0, size1, amp0); ZRL; (run2, size3, amp111b); EOB.
4. Only zz[63]=1 -> DC(0,0); ZRL x3; (run14, size1, amp1); no EOB; in_ready high the cycle after the last accept.
5. Repeat case 3 with sym_ready low 3 cycles per symbol -> identical sequence; outputs stable while stalled; in_valid ignored while in_ready=0.
6. rst pulse during AC of a DC=9 block, then a block with DC=4 -> DC size=3 amp=100b. Separately, dc_clear with in_valid on a block with DC=-3 after a block with DC=6 -> diff=-3, size=2 amp=00b.
